i2c_sslave: RTL and testbench
=============================

Name: i2c_sslave

Overview:
- I2C slave (responder) that emulates a 24C08-style EEPROM at the far end of the bus driven by i2c_mmaster.
- Decodes START/STOP, device address and word address, then performs sequential writes and reads against an external byte RAM (bufram-style, registered read).
- Used in simulation benches and on-board loopback as the target for the master test harness.

Parameters:
- DEV_HI, 5'b10100, upper five device-address bits to match; the low two address bits select page (memory address [9:8]).
- WPAGE_BITS, 4, write-page size is 2^WPAGE_BITS bytes; the pointer's low bits wrap inside the page on writes.
- FILT, 3, consecutive equal samples required to accept a new SCL/SDA level.

Ports:
- clock_i  in  1  system clock; must be at least 16x SCL frequency.
- reset_i  in  1  asynchronous, active-low reset.
- scl_i  in  1  bus SCL level (open-drain, never driven by this block).
- sda_i  in  1  bus SDA level.
- sda_oe_o  out  1  1 = pull SDA low; top level ties sda = sda_oe_o ? 0 : z.
- mem_adr_o  out  10  RAM address (current pointer).
- mem_dat_o  out  8  RAM write data.
- mem_we_o  out  1  RAM write strobe, one-cycle pulse.
- mem_dat_i  in  8  RAM read data, valid one clock after mem_adr_o changes.
- busy_o  out  1  1 from an addressed START (address match) until STOP, NACK-end or mismatch.

Behaviour:
- Input conditioning: 2-FF synchronizer per line, then a FILT-sample filter. All edges and levels below refer to the filtered signals.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are legal in any state. START (including repeated START) goes to DEVADR with bit count 0. STOP goes to IDLE, releases SDA and discards any partial byte.
- Bits are sampled on the SCL rising edge, MSB first. sda_oe_o changes only on the SCL falling edge (the filter delay provides hold time).
- States: IDLE, DEVADR, DEVACK, WADR, WADRACK, WDATA, WDACK, RDATA, RACK, WAITSTOP.
- DEVADR: after 8 bits, if byte[7:3]==DEV_HI, load pointer[9:8]=byte[2:1], assert busy_o, and drive ACK (sda_oe_o=1) for the 9th clock. On mismatch go to WAITSTOP with no ACK.
- Write path (R/W=0): WADR receives the word address into pointer[7:0] and ACKs. In WDATA, each complete byte produces mem_dat_o=byte, mem_adr_o=pointer and mem_we_o=1 for exactly one clock, two clocks after the 8th rising edge. The block then ACKs. The pointer increments only in bits [WPAGE_BITS-1:0], so the page wraps and the upper bits are held.
- Read path (R/W=1, current-address read): the pointer drives mem_adr_o. The shift register loads mem_dat_i on the SCL falling edge that ends DEVACK or RACK. sda_oe_o = ~shift[7] per bit, and SDA is released for the 9th bit. The pointer increments with a full 10-bit wrap (0x3FF to 0x000) at the 9th rising edge. Master ACK (SDA low) goes to RDATA. NACK goes to WAITSTOP, SDA released, busy_o=0.
- WAITSTOP: ignore everything until START or STOP.
- The pointer persists across transactions; a STOP does not clear it.
- Reset: asynchronous. All state goes to IDLE, pointer=0, sda_oe_o=0, mem_we_o=0, mem_adr_o=0, mem_dat_o=0, busy_o=0. SDA is released immediately even mid-byte or mid-ACK.
- A START arriving during an ACK slot releases SDA on the same clock the START is detected.

Test Plan:
- Page write: START, 0xA4 (dev 0x52, page 2), word 0x0E, data 0x11 0x22 0x33, STOP. Required: three ACKs plus the address ACKs; writes land at 0x20E=0x11, 0x20F=0x22, 0x200=0x33 (page wrap); one mem_we_o pulse each.
- Random read: START 0xA4, 0x0E, repeated START 0xA5, read 2 bytes (ACK, then NACK), STOP. Required: SDA carries 0x11, then 0x22; pointer ends at 0x210.
- Current-address read: immediately after the previous case, START 0xA5, one byte, NACK. Required: returns mem[0x210], pointer 0x211; 0x3FF then wraps to 0x000 when preloaded there.
- Address mismatch: START 0xC0 plus 3 bytes. Required: no ACK on any byte, sda_oe_o stays 0, busy_o stays 0, no mem_we_o pulse.
- STOP mid-byte: after the word address, send 5 data bits then STOP. Required: no write, state IDLE, busy_o=0.
- Reset mid-read: assert reset_i=0 while sda_oe_o=1 during RDATA. Required: sda_oe_o=0 asynchronously, pointer=0, and the next transaction decodes normally.

Source files
------------

// File: rtl/i2c_sslave.sv
// I2C responder emulating a 24C08-style EEPROM backed by an external byte RAM
// with registered read. SCL/SDA are synchronized and glitch-filtered before decode.
module i2c_sslave #(
    parameter logic [4:0] DEV_HI     = 5'b10100,
    parameter int         WPAGE_BITS = 4,
    parameter int         FILT       = 3
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [9:0] mem_adr_o,
    output logic [7:0] mem_dat_o,
    output logic       mem_we_o,
    input  logic [7:0] mem_dat_i,
    output logic       busy_o
);

    localparam int             FCW       = $clog2(FILT + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT - 1);
    localparam logic [FCW-1:0] FCNT_ONE  = FCW'(1);
    localparam logic [9:0]     PG_MASK   = 10'((1 << WPAGE_BITS) - 1);

    // IDLE | DEVADR/WADR/WDATA shift in | *ACK our ack slot | RDATA/RACK shift out, master ack | WAITSTOP ignore bus
    typedef enum logic [3:0] {
        S_IDLE, S_DEVADR, S_DEVACK, S_WADR, S_WADRACK,
        S_WDATA, S_WDACK, S_RDATA, S_RACK, S_WAITSTOP
    } state_t;

    logic [1:0]     r_scl_sync, r_sda_sync;
    logic [FCW-1:0] r_scl_cnt, r_sda_cnt;
    logic           r_scl_f, r_sda_f, r_scl_d, r_sda_d;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_bcnt, w_bcnt_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic [9:0]     r_ptr, w_ptr_nxt;
    logic           r_sda_oe, w_oe_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_rw, w_rw_nxt;
    logic           r_wpend, w_wpend_nxt;
    logic           r_we, w_we_nxt;
    logic [7:0]     r_wdat, w_wdat_nxt;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_byte_done, w_last_bit;
    logic [7:0] w_byte;
    logic [9:0] w_ptr_page;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_d    <= r_scl_f;
            r_sda_d    <= r_sda_f;
            if (r_scl_sync[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FILT_LAST) begin
                r_scl_f   <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + FCNT_ONE;
            end
            if (r_sda_sync[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FILT_LAST) begin
                r_sda_f   <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + FCNT_ONE;
            end
        end
    end

    assign w_scl_rise  = r_scl_f & ~r_scl_d;
    assign w_scl_fall  = ~r_scl_f & r_scl_d;
    assign w_start     = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop      = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
    assign w_byte      = {r_shift[6:0], r_sda_f};
    assign w_byte_done = (r_bcnt == 4'd8);
    assign w_last_bit  = (r_bcnt == 4'd7);
    // Write pointer advances inside the page only; upper bits are held.
    assign w_ptr_page  = (r_ptr & ~PG_MASK) | ((r_ptr + 10'd1) & PG_MASK);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= S_IDLE;
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_rw     <= 1'b0;
            r_wpend  <= 1'b0;
            r_we     <= 1'b0;
            r_wdat   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_ptr    <= w_ptr_nxt;
            r_sda_oe <= w_oe_nxt;
            r_busy   <= w_busy_nxt;
            r_rw     <= w_rw_nxt;
            r_wpend  <= w_wpend_nxt;
            r_we     <= w_we_nxt;
            r_wdat   <= w_wdat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_sda_oe;
        w_busy_nxt  = r_busy;
        w_rw_nxt    = r_rw;
        w_wpend_nxt = 1'b0;
        w_we_nxt    = 1'b0;
        w_wdat_nxt  = r_wdat;

        if (r_we) begin
            w_ptr_nxt = w_ptr_page;
        end
        if (r_wpend) begin
            w_we_nxt   = 1'b1;
            w_wdat_nxt = r_shift;
        end

        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_bcnt_nxt  = '0;
        end else if (w_start) begin
            w_state_nxt = S_DEVADR;
            w_oe_nxt    = 1'b0;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                S_DEVADR: begin
                    if (w_scl_rise && !w_byte_done) begin
                        w_shift_nxt = w_byte;
                        w_bcnt_nxt  = r_bcnt + 4'd1;
                        if (w_last_bit) begin
                            if (w_byte[7:3] == DEV_HI) begin
                                w_ptr_nxt[9:8] = w_byte[2:1];
                                w_rw_nxt       = w_byte[0];
                                w_busy_nxt     = 1'b1;
                            end else begin
                                w_state_nxt = S_WAITSTOP;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end else if (w_scl_fall && w_byte_done) begin
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = S_DEVACK;
                    end
                end
                S_DEVACK: begin
                    if (w_scl_fall) begin
                        w_bcnt_nxt = '0;
                        if (r_rw) begin
                            w_shift_nxt = mem_dat_i;
                            w_oe_nxt    = ~mem_dat_i[7];
                            w_state_nxt = S_RDATA;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = S_WADR;
                        end
                    end
                end
                S_WADR: begin
                    if (w_scl_rise && !w_byte_done) begin
                        w_shift_nxt = w_byte;
                        w_bcnt_nxt  = r_bcnt + 4'd1;
                        if (w_last_bit) begin
                            w_ptr_nxt[7:0] = w_byte;
                        end
                    end else if (w_scl_fall && w_byte_done) begin
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = S_WADRACK;
                    end
                end
                S_WDATA: begin
                    if (w_scl_rise && !w_byte_done) begin
                        w_shift_nxt = w_byte;
                        w_bcnt_nxt  = r_bcnt + 4'd1;
                        w_wpend_nxt = w_last_bit;
                    end else if (w_scl_fall && w_byte_done) begin
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = S_WDACK;
                    end
                end
                S_WADRACK, S_WDACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && !w_byte_done) begin
                        w_bcnt_nxt = r_bcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (w_byte_done) begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = S_RACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                S_RACK: begin
                    if (w_scl_rise) begin
                        w_ptr_nxt = r_ptr + 10'd1;
                        if (r_sda_f) begin
                            w_state_nxt = S_WAITSTOP;
                            w_busy_nxt  = 1'b0;
                        end
                    end else if (w_scl_fall) begin
                        w_shift_nxt = mem_dat_i;
                        w_oe_nxt    = ~mem_dat_i[7];
                        w_bcnt_nxt  = '0;
                        w_state_nxt = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe_o  = r_sda_oe;
    assign mem_adr_o = r_ptr;
    assign mem_dat_o = r_wdat;
    assign mem_we_o  = r_we;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_i2c_sslave.sv
// Bench for i2c_sslave: bus-master tasks issue directed transfers, expected ACKs,
// read bytes and RAM writes are queued and checked by separate monitors.
`timescale 1ns/1ps
module tb_i2c_sslave;

    localparam time Q = 100;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe_o, mem_we_o, busy_o;
    logic [9:0] mem_adr_o;
    logic [7:0] mem_dat_o;
    logic [7:0] mem_dat_i;
    logic       preload = 1'b1;
    logic [7:0] mem [1024];

    int vectors = 0;
    int miscompares = 0;
    int oe_hi = 0;
    int busy_hi = 0;

    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    logic [17:0] wr_q[$];
    logic [17:0] wr_e;

    always #5 clock_i = ~clock_i;

    assign sda_line = sda_m & ~sda_oe_o;

    i2c_sslave dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe_o (sda_oe_o),
        .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o),
        .mem_we_o (mem_we_o),
        .mem_dat_i(mem_dat_i),
        .busy_o   (busy_o)
    );

    // Registered-read RAM, preloaded with mem[a] = a[7:0] ^ 0x5A.
    always @(posedge clock_i) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_we_o) begin
            mem[mem_adr_o] <= mem_dat_o;
        end
        mem_dat_i <= mem[mem_adr_o];
    end

    always @(negedge clock_i) begin
        if (sda_oe_o) oe_hi <= oe_hi + 1;
        if (busy_o) busy_hi <= busy_hi + 1;
    end

    always @(negedge clock_i) begin
        if (mem_we_o) begin
            vectors++;
            if (wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got adr=%h dat=%h, required no write", mem_adr_o, mem_dat_o);
            end else begin
                wr_e = wr_q.pop_front();
                if ({mem_adr_o, mem_dat_o} !== wr_e) begin
                    miscompares++;
                    $display("FAIL wr_data: got adr=%h dat=%h, required adr=%h dat=%h",
                             mem_adr_o, mem_dat_o, wr_e[17:8], wr_e[7:0]);
                end
            end
        end
    end

    initial begin : ev_monitor
        logic [15:0] a, e;
        forever begin
            @(negedge clock_i);
            while (act_q.size() > 0) begin
                a = act_q.pop_front();
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL ev_unexpected: got %h, required nothing", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL %s: got %h, required %h", (e[15:8] == 8'h01) ? "ack_bit" : "rd_byte", a[7:0], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic start_c();
        sda_m = 1'b1; scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic rstart_c();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic wbit(input logic b);
        sda_m = b; #(Q);
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b = sda_line; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, input logic exp_ack);
        logic b;
        exp_q.push_back({8'h01, 7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        act_q.push_back({8'h01, 7'd0, b});
    endtask

    task automatic rbyte(input logic [7:0] exp_d, input logic nack);
        logic [7:0] d;
        logic b;
        exp_q.push_back({8'h02, exp_d});
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        act_q.push_back({8'h02, d});
        wbit(nack);
    endtask

    task automatic idle();
        repeat (10) @(negedge clock_i);
    endtask

    initial begin
        int oe0, busy0;
        repeat (3) @(negedge clock_i);
        chk("rst_oe", 16'(sda_oe_o), 16'd0);
        chk("rst_busy", 16'(busy_o), 16'd0);
        chk("rst_adr", 16'(mem_adr_o), 16'd0);
        chk("rst_we", 16'(mem_we_o), 16'd0);
        preload = 1'b0;
        reset_i = 1'b1;
        repeat (5) @(negedge clock_i);

        // page write with wrap inside the 16-byte page
        start_c();
        wbyte(8'hA4, 1'b0);
        chk("wr_busy", 16'(busy_o), 16'd1);
        wbyte(8'h0E, 1'b0);
        wr_q.push_back({10'h20E, 8'h11}); wbyte(8'h11, 1'b0);
        wr_q.push_back({10'h20F, 8'h22}); wbyte(8'h22, 1'b0);
        wr_q.push_back({10'h200, 8'h33}); wbyte(8'h33, 1'b0);
        stop_c(); idle();
        chk("wr_ptr", 16'(mem_adr_o), 16'h201);
        chk("wr_busy_end", 16'(busy_o), 16'd0);

        // random read
        start_c();
        wbyte(8'hA4, 1'b0);
        wbyte(8'h0E, 1'b0);
        rstart_c();
        wbyte(8'hA5, 1'b0);
        rbyte(8'h11, 1'b0);
        rbyte(8'h22, 1'b1);
        chk("rd_busy_nack", 16'(busy_o), 16'd0);
        stop_c(); idle();
        chk("rd_ptr", 16'(mem_adr_o), 16'h210);

        // current-address read
        start_c();
        wbyte(8'hA5, 1'b0);
        rbyte(8'h4A, 1'b1);
        stop_c(); idle();
        chk("cur_ptr", 16'(mem_adr_o), 16'h211);

        // full 10-bit wrap on reads
        start_c();
        wbyte(8'hA6, 1'b0);
        wbyte(8'hFF, 1'b0);
        rstart_c();
        wbyte(8'hA7, 1'b0);
        rbyte(8'hA5, 1'b0);
        rbyte(8'h5A, 1'b1);
        stop_c(); idle();
        chk("wrap_ptr", 16'(mem_adr_o), 16'h001);

        // address mismatch
        oe0 = oe_hi; busy0 = busy_hi;
        start_c();
        wbyte(8'hC0, 1'b1);
        wbyte(8'h12, 1'b1);
        wbyte(8'h34, 1'b1);
        wbyte(8'h56, 1'b1);
        stop_c(); idle();
        chk("mm_oe_cycles", 16'(oe_hi - oe0), 16'd0);
        chk("mm_busy_cycles", 16'(busy_hi - busy0), 16'd0);

        // STOP in the middle of a data byte
        start_c();
        wbyte(8'hA4, 1'b0);
        wbyte(8'h30, 1'b0);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0); wbit(1'b1);
        stop_c(); idle();
        chk("stopmid_busy", 16'(busy_o), 16'd0);
        chk("stopmid_ptr", 16'(mem_adr_o), 16'h230);
        start_c();
        wbyte(8'hA4, 1'b0);
        wbyte(8'h31, 1'b0);
        wr_q.push_back({10'h231, 8'h77}); wbyte(8'h77, 1'b0);
        stop_c(); idle();
        chk("stopmid_next_ptr", 16'(mem_adr_o), 16'h232);

        // reset while driving read data (mem[0x232] = 0x68, MSB low)
        start_c();
        wbyte(8'hA5, 1'b0);
        chk("rstmid_drive", 16'(sda_oe_o), 16'd1);
        reset_i = 1'b0;
        #1;
        chk("rstmid_oe", 16'(sda_oe_o), 16'd0);
        chk("rstmid_ptr", 16'(mem_adr_o), 16'd0);
        chk("rstmid_busy", 16'(busy_o), 16'd0);
        @(negedge clock_i);
        reset_i = 1'b1;
        repeat (5) @(negedge clock_i);
        stop_c(); idle();

        start_c();
        wbyte(8'hA0, 1'b0);
        wbyte(8'h05, 1'b0);
        wr_q.push_back({10'h005, 8'h9C}); wbyte(8'h9C, 1'b0);
        stop_c(); idle();
        start_c();
        wbyte(8'hA0, 1'b0);
        wbyte(8'h05, 1'b0);
        rstart_c();
        wbyte(8'hA1, 1'b0);
        rbyte(8'h9C, 1'b1);
        stop_c(); idle();
        chk("post_rst_ptr", 16'(mem_adr_o), 16'h006);

        for (int k = 0; k < 100 && (act_q.size() > 0 || wr_q.size() > 0); k++) @(negedge clock_i);
        chk("ev_left", 16'(exp_q.size()), 16'd0);
        chk("wr_left", 16'(wr_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
